// File: rtl/tetris_pkg.sv
// Shared definitions for the Tetris board renderer: cell colour codes,
// board-size defaults, FSM state type and the cell-to-RGB palette.
package tetris_pkg;

    localparam int unsigned DEF_BOARD_COLS = 10;
    localparam int unsigned DEF_BOARD_ROWS = 20;

    localparam logic [2:0] COLOR_EMPTY = 3'd0;
    localparam logic [2:0] COLOR_I     = 3'd1;
    localparam logic [2:0] COLOR_O     = 3'd2;
    localparam logic [2:0] COLOR_T     = 3'd3;
    localparam logic [2:0] COLOR_S     = 3'd4;
    localparam logic [2:0] COLOR_Z     = 3'd5;
    localparam logic [2:0] COLOR_J     = 3'd6;
    localparam logic [2:0] COLOR_L     = 3'd7;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic logic [11:0] palette_rgb(input logic [2:0] code);
        logic [11:0] rgb;
        case (code)
            COLOR_EMPTY: rgb = 12'h000;
            COLOR_I:     rgb = 12'h0FF;
            COLOR_O:     rgb = 12'hFF0;
            COLOR_T:     rgb = 12'hA0F;
            COLOR_S:     rgb = 12'h0F0;
            COLOR_Z:     rgb = 12'hF00;
            COLOR_J:     rgb = 12'h00F;
            COLOR_L:     rgb = 12'hF80;
            default:     rgb = 12'h000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/tetris_cell_ram.sv
// Simple dual-port cell map: one write port, one registered read port.
// A same-cycle read and write of one address returns the previous contents.
module tetris_cell_ram #(
    parameter int unsigned DEPTH = 200,
    parameter int unsigned AW    = 8,
    parameter int unsigned DW    = 3
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:DEPTH-1];
    logic [DW-1:0] rdata_q;

    // Write port and registered read port; no reset on the storage array
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tetris_board_renderer.sv
// Three-stage pixel pipeline rendering the Tetris board, plus the clear-sweep FSM.
// Optional build macro GRID_LINES_EN draws dark grid lines on cell edges.
module tetris_board_renderer
    import tetris_pkg::*;
#(
    parameter int unsigned CELL_SHIFT = 4,
    parameter int unsigned BOARD_COLS = DEF_BOARD_COLS,
    parameter int unsigned BOARD_ROWS = DEF_BOARD_ROWS,
    parameter int unsigned ORIGIN_X   = 240,
    parameter int unsigned ORIGIN_Y   = 80,
    parameter int unsigned BORDER_PX  = 2,
    parameter logic        SYNC_IDLE  = 1'b1
) (
    input  logic       pixel_clk,
    input  logic       reset,
    input  logic [9:0] column,
    input  logic [8:0] row,
    input  logic       disp_ena,
    input  logic       h_sync_in,
    input  logic       v_sync_in,
    input  logic       wr_en,
    input  logic [3:0] wr_x,
    input  logic [4:0] wr_y,
    input  logic [2:0] wr_color,
    input  logic       clear_req,
    output logic       wr_ready,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       h_sync_out,
    output logic       v_sync_out,
    output logic       disp_ena_out,
    output logic       frame_start
);

    localparam int unsigned N  = BOARD_COLS * BOARD_ROWS;
    localparam int unsigned AW = $clog2(N);

    localparam logic signed [10:0] ORG_X   = 11'(ORIGIN_X);
    localparam logic signed [10:0] ORG_Y   = 11'(ORIGIN_Y);
    localparam logic signed [10:0] BOARD_W = 11'(BOARD_COLS << CELL_SHIFT);
    localparam logic signed [10:0] BOARD_H = 11'(BOARD_ROWS << CELL_SHIFT);
    localparam logic signed [10:0] BORDER  = 11'(BORDER_PX);
    localparam logic [AW-1:0]      LAST_ADDR = AW'(N - 1);

    // ---------------- clear FSM and write port ----------------
    clr_state_e    state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic          ram_we_s;
    logic [AW-1:0] ram_waddr_s;
    logic [2:0]    ram_wdata_s;
    logic          wr_in_range_s;

    assign wr_in_range_s = ({1'b0, wr_x} < 5'(BOARD_COLS)) && ({1'b0, wr_y} < 6'(BOARD_ROWS));
    assign wr_ready      = (state_q == ST_IDLE);

    // FSM state and sweep address register
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state and write-port steering; a clear request always beats a cell write
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = COLOR_EMPTY;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (wr_en && wr_in_range_s) begin
                    ram_we_s    = 1'b1;
                    ram_waddr_s = AW'(wr_y) * AW'(BOARD_COLS) + AW'(wr_x);
                    ram_wdata_s = wr_color;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                ram_we_s    = 1'b1;
                ram_waddr_s = clr_addr_q;
                ram_wdata_s = COLOR_EMPTY;
                if (clear_req) begin
                    clr_addr_d = '0;
                end else if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            default: begin
                state_d    = ST_CLEAR;
                clr_addr_d = '0;
            end
        endcase
    end

    // ---------------- S1: board geometry ----------------
    logic signed [10:0] dx_s, dy_s;
    logic               in_board_d, in_border_d, grid_d, fs_d;
    logic [3:0]         cx_d;
    logic [4:0]         cy_d;

    logic       s1_board_q, s1_border_q, s1_grid_q, s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q;
    logic [3:0] s1_cx_q;
    logic [4:0] s1_cy_q;

    // Pixel offsets from the board origin and region classification
    always_comb begin
        dx_s        = $signed({1'b0, column}) - ORG_X;
        dy_s        = $signed({2'b00, row}) - ORG_Y;
        in_board_d  = (dx_s >= 11'sd0) && (dx_s < BOARD_W) &&
                      (dy_s >= 11'sd0) && (dy_s < BOARD_H);
        in_border_d = (dx_s >= -BORDER) && (dx_s < BOARD_W + BORDER) &&
                      (dy_s >= -BORDER) && (dy_s < BOARD_H + BORDER) && !in_board_d;
        cx_d        = dx_s[CELL_SHIFT +: 4];
        cy_d        = dy_s[CELL_SHIFT +: 5];
`ifdef GRID_LINES_EN
        grid_d      = (dx_s[CELL_SHIFT-1:0] == '0) || (dy_s[CELL_SHIFT-1:0] == '0);
`else
        grid_d      = 1'b0;
`endif
        fs_d        = (column == 10'd0) && (row == 9'd0) && disp_ena;
    end

    // Stage 1 registers
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s1_board_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_grid_q   <= 1'b0;
            s1_cx_q     <= 4'd0;
            s1_cy_q     <= 5'd0;
            s1_de_q     <= 1'b0;
            s1_hs_q     <= SYNC_IDLE;
            s1_vs_q     <= SYNC_IDLE;
            s1_fs_q     <= 1'b0;
        end else begin
            s1_board_q  <= in_board_d;
            s1_border_q <= in_border_d;
            s1_grid_q   <= grid_d;
            s1_cx_q     <= cx_d;
            s1_cy_q     <= cy_d;
            s1_de_q     <= disp_ena;
            s1_hs_q     <= h_sync_in;
            s1_vs_q     <= v_sync_in;
            s1_fs_q     <= fs_d;
        end
    end

    // ---------------- S2: cell RAM read ----------------
    logic [AW-1:0] ram_raddr_s;
    logic [2:0]    ram_rdata_s;
    logic          s2_board_q, s2_border_q, s2_grid_q, s2_de_q, s2_hs_q, s2_vs_q, s2_fs_q;

    // Off-board pixels read address 0 so the read never leaves the array
    always_comb begin
        if (s1_board_q) begin
            ram_raddr_s = AW'(s1_cy_q) * AW'(BOARD_COLS) + AW'(s1_cx_q);
        end else begin
            ram_raddr_s = '0;
        end
    end

    tetris_cell_ram #(
        .DEPTH (N),
        .AW    (AW),
        .DW    (3)
    ) u_cell_ram (
        .clk_i   (pixel_clk),
        .we_i    (ram_we_s),
        .waddr_i (ram_waddr_s),
        .wdata_i (ram_wdata_s),
        .raddr_i (ram_raddr_s),
        .rdata_o (ram_rdata_s)
    );

    // Stage 2 side-band registers, aligned with the RAM read data
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s2_board_q  <= 1'b0;
            s2_border_q <= 1'b0;
            s2_grid_q   <= 1'b0;
            s2_de_q     <= 1'b0;
            s2_hs_q     <= SYNC_IDLE;
            s2_vs_q     <= SYNC_IDLE;
            s2_fs_q     <= 1'b0;
        end else begin
            s2_board_q  <= s1_board_q;
            s2_border_q <= s1_border_q;
            s2_grid_q   <= s1_grid_q;
            s2_de_q     <= s1_de_q;
            s2_hs_q     <= s1_hs_q;
            s2_vs_q     <= s1_vs_q;
            s2_fs_q     <= s1_fs_q;
        end
    end

    // ---------------- S3: colour select and output registers ----------------
    logic [11:0] rgb_d, rgb_q;
    logic        de_out_q, hs_out_q, vs_out_q, fs_out_q;

    // Colour priority: blanking, frame, cell (grid lines over palette), background
    always_comb begin
        rgb_d = 12'h000;
        if (!s2_de_q) begin
            rgb_d = 12'h000;
        end else if (s2_border_q) begin
            rgb_d = 12'hFFF;
        end else if (s2_board_q) begin
            if (s2_grid_q) begin
                rgb_d = 12'h333;
            end else begin
                rgb_d = palette_rgb(ram_rdata_s);
            end
        end else begin
            rgb_d = 12'h000;
        end
    end

    // Output registers
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            rgb_q    <= 12'h000;
            de_out_q <= 1'b0;
            hs_out_q <= SYNC_IDLE;
            vs_out_q <= SYNC_IDLE;
            fs_out_q <= 1'b0;
        end else begin
            rgb_q    <= rgb_d;
            de_out_q <= s2_de_q;
            hs_out_q <= s2_hs_q;
            vs_out_q <= s2_vs_q;
            fs_out_q <= s2_fs_q;
        end
    end

    assign red          = rgb_q[11:8];
    assign green        = rgb_q[7:4];
    assign blue         = rgb_q[3:0];
    assign disp_ena_out = de_out_q;
    assign h_sync_out   = hs_out_q;
    assign v_sync_out   = vs_out_q;
    assign frame_start  = fs_out_q;

endmodule
